// File: rtl/btn_deb_ev.sv
// Multi-channel push-button conditioner: 2-FF sync, polarity normalise,
// stable-count debounce, press/release one-shots and long-press detection.
module btn_deb_ev #(
  parameter int BTN_WIDTH   = 8,
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int DEB_MS      = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [BTN_WIDTH-1:0] btn_long,
  output logic [BTN_WIDTH-1:0] btn_hold
);

  localparam int DEB_CYC  = CLK_FREQ_HZ / 1000 * DEB_MS;
  localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int DEB_W    = $clog2(DEB_CYC);
  localparam int HOLD_W   = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_CYC > 0) ? (LONG_CYC - 1) : 0);
  localparam logic              IDLE_LVL  = (ACTIVE_LOW != 0);

  logic [BTN_WIDTH-1:0] r_s1;
  logic [BTN_WIDTH-1:0] r_s2;
  logic [BTN_WIDTH-1:0] w_raw;

  // Synchroniser resets to the idle pin level so reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= {BTN_WIDTH{IDLE_LVL}};
      r_s2 <= {BTN_WIDTH{IDLE_LVL}};
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  assign w_raw = r_s2 ^ {BTN_WIDTH{IDLE_LVL}};

  for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_ch
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_lvl;
    logic             r_prs;
    logic             r_rel;
    logic             w_commit;
    logic             w_fall;

    assign w_commit = (w_raw[g] != r_lvl) && (r_deb_cnt == DEB_LAST);
    assign w_fall   = w_commit && r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_deb_cnt <= '0;
        r_lvl     <= 1'b0;
        r_prs     <= 1'b0;
        r_rel     <= 1'b0;
      end else begin
        r_prs <= w_commit && !r_lvl;
        r_rel <= w_fall;
        if (w_raw[g] == r_lvl) begin
          r_deb_cnt <= '0;
        end else if (w_commit) begin
          r_deb_cnt <= '0;
          r_lvl     <= ~r_lvl;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end

    assign btn_level[g]   = r_lvl;
    assign btn_press[g]   = r_prs;
    assign btn_release[g] = r_rel;

    if (LONG_CYC > 0) begin : g_long
      logic [HOLD_W-1:0] r_hold_cnt;
      logic              r_long_p;
      logic              r_hold_l;
      logic              w_hit;

      // A release landing on the threshold edge wins; no long pulse is emitted.
      assign w_hit = r_lvl && !w_fall && !r_hold_l && (r_hold_cnt == HOLD_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold_cnt <= '0;
          r_long_p   <= 1'b0;
          r_hold_l   <= 1'b0;
        end else begin
          r_long_p <= w_hit;
          if (w_fall) begin
            r_hold_l <= 1'b0;
          end else if (w_hit) begin
            r_hold_l <= 1'b1;
          end
          if (!r_lvl) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
      end

      assign btn_long[g] = r_long_p;
      assign btn_hold[g] = r_hold_l;
    end else begin : g_nolong
      assign btn_long[g] = 1'b0;
      assign btn_hold[g] = 1'b0;
    end
  end

endmodule

// File: doc/btn_deb_ev.md
Name: btn_deb_ev

Overview:
Multi-channel push-button conditioner for the board's key inputs.
- Synchronises raw button pins and debounces each channel with a time-based stable-count filter.
- Normalises polarity to pressed = 1.
- Emits per-channel press and release one-shot events, plus long-press detection.
- Sits between the top-level button pins and the mode/menu control logic. Downstream logic consumes clean levels and single-cycle events only.

Parameters:
- BTN_WIDTH, 8: number of button channels.
- CLK_FREQ_HZ, 12_000_000: clk frequency in Hz.
- DEB_MS, 20: debounce window in ms. DEB_CYC = CLK_FREQ_HZ/1000*DEB_MS; must be >= 2.
- LONG_MS, 1000: long-press threshold in ms. LONG_CYC = CLK_FREQ_HZ/1000*LONG_MS. 0 disables long-press.
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- Counter widths are localparams derived with $clog2 of DEB_CYC and LONG_CYC.

Ports:
- clk, input, 1: single system clock; all logic in this domain.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_in, input, BTN_WIDTH: raw asynchronous button pins.
- btn_level, output, BTN_WIDTH: debounced level, 1 = pressed.
- btn_press, output, BTN_WIDTH: 1-cycle pulse on each debounced press.
- btn_release, output, BTN_WIDTH: 1-cycle pulse on each debounced release.
- btn_long, output, BTN_WIDTH: 1-cycle pulse when a press has been held LONG_CYC cycles.
- btn_hold, output, BTN_WIDTH: level, 1 from the btn_long pulse until release.

Behaviour:
Clock and reset
- One clock, clk. Reset is asynchronous, active-low on rst_n; all registers clear immediately on assertion.
- Reset values: all outputs 0; all counters 0; synchroniser flops loaded with the idle pin level (ACTIVE_LOW ? 1 : 0).

Synchroniser and normalisation
- Per bit, a 2-FF synchroniser: s1 <= btn_in, s2 <= s1.
- raw = s2 XOR ACTIVE_LOW.

Debounce (per channel, independent)
- deb_cnt counts consecutive cycles where raw != btn_level. It clears to 0 on any cycle where raw == btn_level (a glitch restarts the window).
- When deb_cnt == DEB_CYC-1 and raw != btn_level: btn_level toggles and deb_cnt clears to 0.
- Latency: if edge k is the first clk edge that samples the new pin value into s1, btn_level changes at edge k+DEB_CYC+1, provided the pin is stable throughout.
- Any mismatch run shorter than DEB_CYC cycles produces no output change.

Events
- btn_press/btn_release are registered and assert on the same edge btn_level rises/falls, for exactly one cycle.
- Both are never asserted on the same channel in the same cycle.

Long-press
- hold_cnt increments while btn_level == 1 and clears to 0 when btn_level == 0.
- At hold_cnt == LONG_CYC-1: btn_long pulses for one cycle, btn_hold sets, and hold_cnt saturates (no further btn_long until release).
- btn_hold clears on the same edge btn_release pulses.
- btn_long therefore fires LONG_CYC edges after the btn_level rising edge.
- LONG_MS == 0: btn_long and btn_hold are tied 0 and the hold counter is removed.

Boundary conditions
- Reset mid-operation: outputs drop to 0 with no release pulse. If the button is still held after rst_n deasserts, it is re-detected as a new press with a btn_press pulse, using the normal latency.
- Channels are fully independent; simultaneous events on multiple channels are all reported in the same cycle.
- No counter wraps: deb_cnt is bounded by the commit condition; hold_cnt saturates.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, DEB_MS=4 (DEB_CYC=4), LONG_MS=10 (LONG_CYC=10), ACTIVE_LOW=1, BTN_WIDTH=4.
1. Reset: rst_n=0 with btn_in=4'hF, then release and idle 30 cycles -> all outputs 0 throughout, no event pulses.
2. Clean press: btn_in[0] 1->0, first sampled at edge k, held -> btn_level[0]=1 and btn_press[0] high for one cycle at edge k+5; bits 1-3 stay 0.
3. Bounce: btn_in[1] low 3 cycles, high 1 cycle, then low steady from edge j -> exactly one btn_press[1] pulse, at edge j+5; nothing before.
4. Long-press: hold ch0 -> btn_long[0] pulse and btn_hold[0]=1 10 edges after the btn_level[0] rise; hold 30 more cycles -> no second btn_long; release -> btn_release[0] pulse and btn_hold[0]=0 on the same edge btn_level[0] falls.
5. Release glitch: while ch2 is pressed, drive btn_in[2] high for 3 cycles -> no btn_release[2], btn_level[2] stays 1, hold progress unaffected.
6. Reset mid-hold plus simultaneous channels: press ch0 and ch3 on the same edge -> both btn_press bits pulse in the same cycle. Then assert rst_n with ch0 still held -> outputs 0 immediately; after deassert -> new btn_press[0] DEB_CYC+1 edges after the first post-reset sampling edge.
